// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg
// Shared definitions for the memory request scheduler: rw encodings, a
// request record at the default bus widths, and the id-width helper used to
// size requester identifiers.
// The scheduler builds its own width-parameterised request record. This
// default-width record is the form the surrounding code and the bench use.
package mem_sched_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 64;

    typedef struct packed {
        logic                  rw;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    // Width of a requester id. It never drops below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_sched_if.sv
// mem_req_sched_if
// Bundles the requester-side and memory-side signals of the scheduler.
//   slave  : the scheduler's view. It receives requests and responses and
//            drives grants, the staged request and the response strobes.
//   master : the environment's view. It is the mirror image of slave.
// Signals:
//   io_in_valid/ready/bits_rw/bits_addr/bits_data : per-requester request bus
//   io_mem_req_valid/ready/rw/addr/data/id        : single memory request port
//   io_mem_resp_valid/data                        : memory read response
//   io_resp_valid/data                            : routed response to requesters
interface mem_req_sched_if
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        io_in_valid;
    logic [NUM_REQ-1:0]        io_in_ready;
    logic [NUM_REQ-1:0]        io_in_bits_rw;
    logic [NUM_REQ*ADDR_W-1:0] io_in_bits_addr;
    logic [NUM_REQ*DATA_W-1:0] io_in_bits_data;

    logic                      io_mem_req_valid;
    logic                      io_mem_req_ready;
    logic                      io_mem_req_rw;
    logic [ADDR_W-1:0]         io_mem_req_addr;
    logic [DATA_W-1:0]         io_mem_req_data;
    logic [ID_W-1:0]           io_mem_req_id;

    logic                      io_mem_resp_valid;
    logic [DATA_W-1:0]         io_mem_resp_data;

    logic [NUM_REQ-1:0]        io_resp_valid;
    logic [DATA_W-1:0]         io_resp_data;

    modport slave (
        input  io_in_valid, io_in_bits_rw, io_in_bits_addr, io_in_bits_data,
        output io_in_ready,
        output io_mem_req_valid, io_mem_req_rw, io_mem_req_addr, io_mem_req_data, io_mem_req_id,
        input  io_mem_req_ready,
        input  io_mem_resp_valid, io_mem_resp_data,
        output io_resp_valid, io_resp_data
    );

    modport master (
        output io_in_valid, io_in_bits_rw, io_in_bits_addr, io_in_bits_data,
        input  io_in_ready,
        input  io_mem_req_valid, io_mem_req_rw, io_mem_req_addr, io_mem_req_data, io_mem_req_id,
        output io_mem_req_ready,
        output io_mem_resp_valid, io_mem_resp_data,
        input  io_resp_valid, io_resp_data
    );

endinterface

// File: rtl/mem_sched_tag_fifo.sv
// mem_sched_tag_fifo
// Circular buffer of requester ids for outstanding reads. It holds the ids
// in the order the reads were accepted, so that responses can be routed back
// in order.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   push, push_tag     : append an id (caller guarantees !full)
//   pop                : drop the head (caller guarantees !empty)
//   full, empty, count : occupancy, all derived from the registered count
//   head               : oldest id. A push becomes visible here one cycle later.
module mem_sched_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [TAG_W-1:0]           head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/mem_req_sched.sv
// mem_req_sched
// Shares one memory request port among NUM_REQ requesters. It uses
// round-robin arbitration, a single output register stage, and in-order
// routing of read responses through a tag FIFO of requester ids.
// Optional feature macro: MEM_SCHED_ERR_EN. When it is defined, the module
// adds the io_err port, a sticky flag that is set by a response arriving
// with no outstanding read.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   io_err     : sticky orphan-response flag (MEM_SCHED_ERR_EN only)
//   bus        : mem_req_sched_if.slave, with the requester and memory buses
module mem_req_sched
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef MEM_SCHED_ERR_EN
    output logic io_err,
`endif
    mem_req_sched_if.slave bus
);
    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    int                 idx;
    req_t               win_req;

    logic               can_load;
    logic               in_hs;
    logic [ID_W-1:0]    last_grant;
    logic               stage_valid;
    req_t               stage_q;
    logic [ID_W-1:0]    stage_id;

    logic               tag_push;
    logic               tag_pop;
    logic               tag_full;
    logic               tag_empty;
    logic               tag_at_depth;
    logic [CNT_W-1:0]   tag_count;
    logic [ID_W-1:0]    tag_head;

    // Reads are held back on the registered count alone. A response that
    // pops in the same cycle does not free a slot until the next cycle.
    assign tag_at_depth = (tag_count == CNT_W'(TAG_DEPTH));

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.io_in_valid[i] & (bus.io_in_bits_rw[i] | ~tag_at_depth);
        end
    end

    // Search from last_grant+1 upward, wrapping. The first eligible requester wins.
    always_comb begin
        win       = '0;
        win_id    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found   = 1'b1;
                win[idx]    = 1'b1;
                win_id      = ID_W'(idx);
            end
        end
    end

    always_comb begin
        win_req.rw   = bus.io_in_bits_rw[win_id];
        win_req.addr = bus.io_in_bits_addr[int'(win_id)*ADDR_W +: ADDR_W];
        win_req.data = bus.io_in_bits_data[int'(win_id)*DATA_W +: DATA_W];
    end

    assign can_load        = ~stage_valid | bus.io_mem_req_ready;
    assign in_hs           = win_found & can_load & ~reset;
    assign bus.io_in_ready = win & {NUM_REQ{can_load & ~reset}};

    // last_grant moves only on a real handshake, so a stalled grant keeps its priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
            last_grant  <= ID_W'(NUM_REQ - 1);
        end else if (in_hs) begin
            stage_valid <= 1'b1;
            last_grant  <= win_id;
        end else if (stage_valid && bus.io_mem_req_ready) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            stage_q  <= win_req;
            stage_id <= win_id;
        end
    end

    assign bus.io_mem_req_valid = stage_valid;
    assign bus.io_mem_req_rw    = stage_q.rw;
    assign bus.io_mem_req_addr  = stage_q.addr;
    assign bus.io_mem_req_data  = stage_q.data;
    assign bus.io_mem_req_id    = stage_id;

    assign tag_push = in_hs & (win_req.rw == RW_READ) & ~tag_full;
    assign tag_pop  = bus.io_mem_resp_valid & ~tag_empty & ~reset;

    mem_sched_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .TAG_W (ID_W)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tag_push),
        .push_tag (win_id),
        .pop      (tag_pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count),
        .head     (tag_head)
    );

    always_comb begin
        bus.io_resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.io_resp_valid[i] = tag_pop & (tag_head == ID_W'(i));
        end
    end

    assign bus.io_resp_data = bus.io_mem_resp_data;

`ifdef MEM_SCHED_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            io_err <= 1'b0;
        end else if (bus.io_mem_resp_valid && tag_empty) begin
            io_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// tb_mem_req_sched
// Directed bench for mem_req_sched at its default parameters. A queue-based
// model of the scheduling rules is compared with the DUT on every cycle.
// Literal expectations at key points of each scenario pin the model itself.
module tb_mem_req_sched;
    import mem_sched_pkg::*;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_sched_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_SCHED_ERR_EN
    logic io_err;
`endif

    mem_req_sched #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MEM_SCHED_ERR_EN
        .io_err (io_err),
`endif
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    bit       m_st_valid = 1'b0;
    mem_req_t m_st;
    int       m_st_id    = 0;
    int       m_last     = N - 1;
    int       m_tags[$];
    bit       m_err      = 1'b0;

    function automatic int m_winner();
        for (int off = 1; off <= N; off++) begin
            int i = (m_last + off) % N;
            if (bus.io_in_valid[i] && (bus.io_in_bits_rw[i] == RW_WRITE || m_tags.size() < TD))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w = m_winner();
        if (reset || w < 0 || (m_st_valid && !bus.io_mem_req_ready)) return '0;
        return N'(1) << w;
    endfunction

    function automatic logic [N-1:0] m_resp();
        if (reset || !bus.io_mem_resp_valid || m_tags.size() == 0) return '0;
        return N'(1) << m_tags[0];
    endfunction

    initial begin
        forever begin
            int  w;
            bit  hs;
            @(posedge clk);
            if (reset) begin
                m_st_valid = 1'b0;
                m_last     = N - 1;
                m_tags.delete();
                m_err      = 1'b0;
            end else begin
                w  = m_winner();
                hs = (m_ready() != '0);
                if (bus.io_mem_resp_valid) begin
                    if (m_tags.size() == 0) m_err = 1'b1;
                    else void'(m_tags.pop_front());
                end
                if (hs) begin
                    m_st_valid = 1'b1;
                    m_st.rw    = bus.io_in_bits_rw[w];
                    m_st.addr  = bus.io_in_bits_addr[w*AW +: AW];
                    m_st.data  = bus.io_in_bits_data[w*DW +: DW];
                    m_st_id    = w;
                    m_last     = w;
                    if (m_st.rw == RW_READ) m_tags.push_back(w);
                end else if (m_st_valid && bus.io_mem_req_ready) begin
                    m_st_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            check("in_ready", bus.io_in_ready, m_ready());
            check("resp_valid", bus.io_resp_valid, m_resp());
            if (m_resp() != '0) check("resp_data", bus.io_resp_data, bus.io_mem_resp_data);
            check("req_valid", bus.io_mem_req_valid, m_st_valid);
            if (m_st_valid) begin
                check("req_id", bus.io_mem_req_id, m_st_id);
                check("req_rw", bus.io_mem_req_rw, m_st.rw);
                check("req_addr", bus.io_mem_req_addr, m_st.addr);
                check("req_data", bus.io_mem_req_data, m_st.data);
            end
`ifdef MEM_SCHED_ERR_EN
            check("err", io_err, m_err);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic rst, input logic [N-1:0] v, input logic [N-1:0] rw,
                       input logic rdy, input logic rv, input logic [DW-1:0] rd);
        @(negedge clk);
        reset                 = rst;
        bus.io_in_valid       = v;
        bus.io_in_bits_rw     = rw;
        bus.io_mem_req_ready  = rdy;
        bus.io_mem_resp_valid = rv;
        bus.io_mem_resp_data  = rd;
        #2;
    endtask

    initial begin
        reset                 = 1'b1;
        bus.io_in_valid       = '1;
        bus.io_in_bits_rw     = '1;
        bus.io_mem_req_ready  = 1'b1;
        bus.io_mem_resp_valid = 1'b0;
        bus.io_mem_resp_data  = '0;
        for (int i = 0; i < N; i++) begin
            bus.io_in_bits_addr[i*AW +: AW] = AW'(12'hA00 + i);
            bus.io_in_bits_data[i*DW +: DW] = 64'hCAFE_0000_0000_0000 + 64'(i);
        end

        // Reset held for two cycles with every requester asking.
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, '0);
            check("rst_in_ready", bus.io_in_ready, 4'b0000);
            check("rst_req_valid", bus.io_mem_req_valid, 1'b0);
        end

        // Round-robin over four writers with the memory always ready.
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, '0);
            check("rr_grant", bus.io_in_ready, 4'b0001 << (k % 4));
            if (k > 0) check("rr_id", bus.io_mem_req_id, (k - 1) % 4);
        end

        // Back-pressure. The stage holds requester 0, the grant stays put, and
        // fields stay stable.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, '0);
            check("bp_in_ready", bus.io_in_ready, 4'b0000);
            check("bp_id", bus.io_mem_req_id, 0);
            check("bp_addr", bus.io_mem_req_addr, 12'hA00);
        end
        cyc(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, '0);
        check("bp_release", bus.io_in_ready, 4'b0010);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);

        // Tag full. Requester 2 reads four times, then its fifth read is held
        // while requester 1's write proceeds.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, '0);
            check("tf_accept", bus.io_in_ready, 4'b0100);
        end
        cyc(1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0, '0);
        check("tf_write_passes", bus.io_in_ready, 4'b0010);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 64'h0000_0000_0000_AAAA);
        check("tf_still_full", bus.io_in_ready, 4'b0000);
        check("tf_resp_valid", bus.io_resp_valid, 4'b0100);
        check("tf_resp_data", bus.io_resp_data, 64'h0000_0000_0000_AAAA);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, '0);
        check("tf_reaccept", bus.io_in_ready, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 64'hB0 + 64'(k));
            check("tf_drain", bus.io_resp_valid, 4'b0100);
        end

        // Response order: reads from 3, 1, 3, then three responses.
        cyc(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, '0);
        check("ro_grant3", bus.io_in_ready, 4'b1000);
        cyc(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, '0);
        check("ro_grant1", bus.io_in_ready, 4'b0010);
        cyc(1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0, '0);
        check("ro_grant3b", bus.io_in_ready, 4'b1000);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 64'hD0D0_0000_0000_0000);
        check("ro_resp0", bus.io_resp_valid, 4'b1000);
        check("ro_data0", bus.io_resp_data, 64'hD0D0_0000_0000_0000);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 64'hD1D1_0000_0000_0001);
        check("ro_resp1", bus.io_resp_valid, 4'b0010);
        check("ro_data1", bus.io_resp_data, 64'hD1D1_0000_0000_0001);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 64'hD2D2_0000_0000_0002);
        check("ro_resp2", bus.io_resp_valid, 4'b1000);
        check("ro_data2", bus.io_resp_data, 64'hD2D2_0000_0000_0002);

        // Orphan response with an empty FIFO.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 64'hDEAD);
        check("orphan_resp", bus.io_resp_valid, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
`ifdef MEM_SCHED_ERR_EN
        check("orphan_err", io_err, 1'b1);
`endif

        // Reset mid-operation drops the outstanding read. Its late response is
        // an orphan.
        cyc(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, '0);
        check("mid_grant", bus.io_in_ready, 4'b0010);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 64'hBEEF);
        check("mid_resp", bus.io_resp_valid, 4'b0000);
        check("mid_req_valid", bus.io_mem_req_valid, 1'b0);
`ifdef MEM_SCHED_ERR_EN
        check("mid_err_cleared", io_err, 1'b0);
`endif
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
`ifdef MEM_SCHED_ERR_EN
        check("mid_err_set", io_err, 1'b1);
`endif
        cyc(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
